// File: rtl/core_seq_pkg.sv
// Shared types and constants for the NPC core sequencer.
package npc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    F_REQ,
    F_WAIT,
    DEC,
    EXE,
    M_REQ,
    M_WAIT,
    WB,
    HALT
  } seq_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/core_seq_if.sv
// Instruction-fetch and load/store handshake bundle between the sequencer and memory.
interface core_seq_if;

  logic        ifu_req_valid_o;
  logic        ifu_req_ready_i;
  logic        ifu_rsp_valid_i;
  logic [31:0] ifu_rsp_data_i;
  logic        lsu_req_valid_o;
  logic        lsu_req_ready_i;
  logic        lsu_rsp_valid_i;

  modport master (
    output ifu_req_valid_o, lsu_req_valid_o,
    input  ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_data_i,
    input  lsu_req_ready_i, lsu_rsp_valid_i
  );

  modport slave (
    input  ifu_req_valid_o, lsu_req_valid_o,
    output ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_data_i,
    output lsu_req_ready_i, lsu_rsp_valid_i
  );

endinterface

// File: rtl/core_seq_watchdog.sv
// Response watchdog: counts consecutive wait cycles and flags the limit.
// Only present when NPC_SEQ_TIMEOUT_EN is defined.
`ifdef NPC_SEQ_TIMEOUT_EN
module seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Count holds at the limit so it cannot wrap while the caller decides.
  assign expired = in_wait && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!in_wait) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/core_seq.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC core.
// Define NPC_SEQ_TIMEOUT_EN to build the response watchdog.
module core_seq
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  core_seq_if.master  bus,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        is_mem_i,
  input  logic        is_ebreak_i,
  input  logic        rd_wen_i,
  input  logic [31:0] next_pc_i,
  output logic        rd_wen_o,
  output logic [63:0] instret_o,
  output logic        halt_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  seq_state_e state_q, state_d;
  logic [1:0] err_code_d;
  logic       misalign;
  logic       timeout;

  assign misalign = (next_pc_i[1:0] != 2'b00);

`ifdef NPC_SEQ_TIMEOUT_EN
  seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_wait ((state_q == F_WAIT) || (state_q == M_WAIT)),
    .expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign bus.ifu_req_valid_o = (state_q == F_REQ);
  assign bus.lsu_req_valid_o = (state_q == M_REQ);
  assign rd_wen_o            = (state_q == WB) && rd_wen_i;

  always_comb begin
    state_d    = state_q;
    err_code_d = ERR_NONE;
    unique case (state_q)
      IDLE:   state_d = F_REQ;
      F_REQ:  if (bus.ifu_req_ready_i) state_d = F_WAIT;
      // A response in the limit cycle takes priority over the timeout.
      F_WAIT: begin
        if (bus.ifu_rsp_valid_i) begin
          state_d = DEC;
        end else if (timeout) begin
          state_d    = HALT;
          err_code_d = ERR_TIMEOUT;
        end
      end
      DEC:    state_d = is_ebreak_i ? HALT : EXE;
      EXE:    state_d = is_mem_i ? M_REQ : WB;
      M_REQ:  if (bus.lsu_req_ready_i) state_d = M_WAIT;
      M_WAIT: begin
        if (bus.lsu_rsp_valid_i) begin
          state_d = WB;
        end else if (timeout) begin
          state_d    = HALT;
          err_code_d = ERR_TIMEOUT;
        end
      end
      WB: begin
        if (misalign) begin
          state_d    = HALT;
          err_code_d = ERR_MISALIGN;
        end else begin
          state_d = F_REQ;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_o       <= RESET_PC;
      inst_o     <= NOP;
      instret_o  <= '0;
      halt_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
    end else begin
      state_q <= state_d;
      if ((state_q == F_WAIT) && bus.ifu_rsp_valid_i) inst_o <= bus.ifu_rsp_data_i;
      // A misaligned target still retires the instruction but leaves the PC alone.
      if (state_q == WB) begin
        instret_o <= instret_o + 64'd1;
        if (!misalign) pc_o <= next_pc_i;
      end
      if ((state_d == HALT) && (state_q != HALT)) begin
        halt_o     <= 1'b1;
        err_o      <= (err_code_d != ERR_NONE);
        err_code_o <= err_code_d;
      end
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: vector table, randomized stalls vs. a latency model,
// and hand-written halt/reset sequences.
module tb_core_seq;
  import npc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct {
    int          r;      // ifu ready-low cycles before acceptance
    int          s;      // ifu rsp-low cycles in F_WAIT
    bit          mem;
    int          lr;     // lsu ready-low cycles
    int          ls;     // lsu rsp-low cycles
    bit          wen;
    logic [31:0] npc;
    logic [31:0] idata;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_o, pc_o, next_pc_i;
  logic        is_mem_i, is_ebreak_i, rd_wen_i, rd_wen_o, halt_o, err_o;
  logic [63:0] instret_o;
  logic [1:0]  err_code_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  logic [63:0] m_instret;
  vec_t tbl [8];

  core_seq_if bus ();

  core_seq #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .inst_o(inst_o), .pc_o(pc_o),
    .is_mem_i(is_mem_i), .is_ebreak_i(is_ebreak_i), .rd_wen_i(rd_wen_i), .next_pc_i(next_pc_i),
    .rd_wen_o(rd_wen_o), .instret_o(instret_o),
    .halt_o(halt_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input vec_t v);
    return 5 + v.r + v.s + (v.mem ? (2 + v.lr + v.ls) : 0);
  endfunction

  task automatic clear_inputs();
    bus.ifu_req_ready_i = 1'b0;
    bus.ifu_rsp_valid_i = 1'b0;
    bus.ifu_rsp_data_i  = 32'h0;
    bus.lsu_req_ready_i = 1'b0;
    bus.lsu_rsp_valid_i = 1'b0;
    is_mem_i = 1'b0; is_ebreak_i = 1'b0; rd_wen_i = 1'b0; next_pc_i = 32'h0;
  endtask

  // Ends in the first F_REQ cycle after release.
  task automatic do_reset();
    clear_inputs();
    rd_wen_i = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ifu_valid", bus.ifu_req_valid_o, 0);
    chk("rst_lsu_valid", bus.lsu_req_valid_o, 0);
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_inst", inst_o, NOP);
    chk("rst_rd_wen", rd_wen_o, 0);
    chk("rst_instret", instret_o, 0);
    chk("rst_halt_err", {halt_o, err_o, err_code_o}, 0);
    rd_wen_i = 1'b0;
    rst_n = 1'b1;
    chk("idle_no_fetch", bus.ifu_req_valid_o, 0);
    step();
    chk("first_fetch", bus.ifu_req_valid_o, 1);
    m_pc = RST_PC;
    m_instret = 64'd0;
  endtask

  task automatic fast_fetch(input logic [31:0] d);
    bus.ifu_req_ready_i = 1'b1;
    step();
    bus.ifu_req_ready_i = 1'b0;
    bus.ifu_rsp_valid_i = 1'b1;
    bus.ifu_rsp_data_i  = d;
    step();
    bus.ifu_rsp_valid_i = 1'b0;
  endtask

  // Acts as fetch/load-store memory for one instruction, starting in its first F_REQ cycle.
  // Stray responses are offered whenever the bench is not waiting for one.
  task automatic run_instr(input vec_t v, output int lat, output int wb, output int np, output int viol);
    int c, fr, fw, mr, mw;
    bit acc, fdone, macc, mdone;
    c = 0; fr = 0; fw = 0; mr = 0; mw = 0;
    acc = 0; fdone = 0; macc = 0; mdone = 0;
    lat = -1; wb = -1; np = 0; viol = 0;
    is_mem_i = v.mem; rd_wen_i = v.wen; next_pc_i = v.npc; is_ebreak_i = 1'b0;
    while (c < 300) begin
      c++;
      if (fdone && bus.ifu_req_valid_o) begin
        lat = c - 1;
        break;
      end
      if (acc && !fdone && bus.ifu_req_valid_o) viol++;
      if (bus.lsu_req_valid_o && (!v.mem || !fdone || macc)) viol++;
      bus.ifu_req_ready_i = 1'b0;
      bus.ifu_rsp_valid_i = 1'($urandom_range(0, 1));
      bus.ifu_rsp_data_i  = $urandom;
      bus.lsu_req_ready_i = 1'b0;
      bus.lsu_rsp_valid_i = 1'($urandom_range(0, 1));
      if (!acc) begin
        if (bus.ifu_req_valid_o) begin
          if (fr == v.r) begin
            bus.ifu_req_ready_i = 1'b1;
            acc = 1;
          end
          fr++;
        end
      end else if (!fdone) begin
        bus.ifu_rsp_valid_i = (fw == v.s);
        bus.ifu_rsp_data_i  = (fw == v.s) ? v.idata : ~v.idata;
        if (fw == v.s) fdone = 1;
        fw++;
      end else if (v.mem && !mdone) begin
        if (!macc) begin
          if (bus.lsu_req_valid_o) begin
            if (mr == v.lr) begin
              bus.lsu_req_ready_i = 1'b1;
              macc = 1;
            end
            mr++;
          end
        end else begin
          bus.lsu_rsp_valid_i = (mw == v.ls);
          if (mw == v.ls) mdone = 1;
          mw++;
        end
      end
      if (rd_wen_o) begin
        np++;
        wb = c;
      end
      step();
    end
  endtask

  task automatic run_and_check(input string name, input vec_t v, input int exp_lat);
    int lat, wb, np, viol;
    run_instr(v, lat, wb, np, viol);
    m_pc = v.npc;
    m_instret = m_instret + 64'd1;
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_wen_pulses"}, np, v.wen);
    if (v.wen) chk({name, "_wen_cycle"}, wb, exp_lat);
    chk({name, "_valid_protocol"}, viol, 0);
    chk({name, "_pc"}, pc_o, m_pc);
    chk({name, "_instret"}, instret_o, m_instret);
    chk({name, "_inst"}, inst_o, v.idata);
  endtask

  initial begin
    vec_t v;
    int nv, nw;
    clear_inputs();

    tbl[0] = '{0, 0, 1'b0, 0, 0, 1'b1, 32'h8000_0004, 32'h0010_0093, 5};
    tbl[1] = '{0, 0, 1'b0, 0, 0, 1'b1, 32'h8000_0008, 32'h0020_0113, 5};
    tbl[2] = '{0, 0, 1'b0, 0, 0, 1'b1, 32'h8000_000C, 32'h0030_0193, 5};
    tbl[3] = '{4, 0, 1'b0, 0, 0, 1'b1, 32'h8000_0010, 32'h0040_0213, 9};
    tbl[4] = '{0, 0, 1'b1, 0, 3, 1'b1, 32'h8000_0014, 32'h0000_a203, 10};
    tbl[5] = '{1, 2, 1'b1, 1, 0, 1'b0, 32'h8000_0100, 32'h0020_a023, 11};
    tbl[6] = '{0, 3, 1'b0, 0, 0, 1'b0, 32'h8000_0104, 32'h0000_8067, 8};
    tbl[7] = '{2, 1, 1'b1, 2, 2, 1'b1, 32'h8000_0108, 32'h0041_2283, 14};

    do_reset();
    for (int i = 0; i < 8; i++) run_and_check($sformatf("vec%0d", i), tbl[i], tbl[i].exp_lat);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] tmp;
      tmp    = $urandom;
      v.r    = $urandom_range(0, 3);
      v.s    = $urandom_range(0, 3);
      v.mem  = 1'($urandom_range(0, 1));
      v.lr   = $urandom_range(0, 3);
      v.ls   = $urandom_range(0, 3);
      v.wen  = 1'($urandom_range(0, 1));
      v.npc  = ($urandom_range(0, 3) == 0) ? (tmp & 32'hFFFF_FFFC) : (m_pc + 32'd4);
      v.idata = $urandom;
      v.exp_lat = 0;
      run_and_check($sformatf("rnd%0d", i), v, model_lat(v));
    end

    // ebreak on the second instruction
    do_reset();
    v = '{0, 0, 1'b0, 0, 0, 1'b1, 32'h8000_0004, 32'h0010_0093, 5};
    run_and_check("eb_first", v, 5);
    fast_fetch(32'h0010_0073);
    is_ebreak_i = 1'b1;
    step();
    is_ebreak_i = 1'b0;
    nv = 0; nw = 0;
    for (int i = 0; i < 50; i++) begin
      nv += int'(bus.ifu_req_valid_o) + int'(bus.lsu_req_valid_o);
      nw += int'(rd_wen_o);
      step();
    end
    chk("eb_halt", halt_o, 1);
    chk("eb_err", {err_o, err_code_o}, 0);
    chk("eb_instret", instret_o, 1);
    chk("eb_no_requests", nv, 0);
    chk("eb_no_wen", nw, 0);
    chk("eb_pc_frozen", pc_o, 32'h8000_0004);
    chk("eb_inst", inst_o, 32'h0010_0073);

    // misaligned next PC
    do_reset();
    fast_fetch(32'h0060_0067);
    is_mem_i = 1'b0; rd_wen_i = 1'b1; next_pc_i = 32'h8000_0006;
    step();
    step();
    chk("mis_wb_wen", rd_wen_o, 1);
    step();
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      nv += int'(bus.ifu_req_valid_o) + int'(rd_wen_o);
      step();
    end
    chk("mis_halt", {halt_o, err_o}, 2'b11);
    chk("mis_code", err_code_o, ERR_MISALIGN);
    chk("mis_pc", pc_o, RST_PC);
    chk("mis_instret", instret_o, 1);
    chk("mis_quiet", nv, 0);

    // reset while a load/store request is pending
    do_reset();
    fast_fetch(32'h0000_a303);
    is_mem_i = 1'b1; rd_wen_i = 1'b1; next_pc_i = 32'h8000_0004;
    step();
    step();
    chk("mreq_valid", bus.lsu_req_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_lsu_valid", bus.lsu_req_valid_o, 0);

    // reset during M_WAIT, then a stale response
    do_reset();
    fast_fetch(32'h0000_a383);
    is_mem_i = 1'b1; rd_wen_i = 1'b1; next_pc_i = 32'h8000_0004;
    step();
    step();
    bus.lsu_req_ready_i = 1'b1;
    step();
    bus.lsu_req_ready_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mw_rst_lsu_valid", bus.lsu_req_valid_o, 0);
    chk("mw_rst_pc", pc_o, RST_PC);
    chk("mw_rst_instret", instret_o, 0);
    @(posedge clk);
    #1;
    bus.lsu_rsp_valid_i = 1'b1;
    rst_n = 1'b1;
    chk("mw_rel_idle", bus.ifu_req_valid_o, 0);
    step();
    chk("mw_rel_fetch", bus.ifu_req_valid_o, 1);
    m_pc = RST_PC; m_instret = 64'd0;
    v = '{0, 1, 1'b0, 0, 0, 1'b1, 32'h8000_0004, 32'h0050_0293, 6};
    run_and_check("after_rst", v, 6);

`ifdef NPC_SEQ_TIMEOUT_EN
    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    step();
    bus.ifu_req_ready_i = 1'b0;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      nv += int'(halt_o);
      step();
    end
    chk("to_no_early_halt", nv, 0);
    chk("to_halt", {halt_o, err_o}, 2'b11);
    chk("to_code", err_code_o, ERR_TIMEOUT);

    do_reset();
    bus.ifu_req_ready_i = 1'b1;
    step();
    bus.ifu_req_ready_i = 1'b0;
    repeat (15) step();
    bus.ifu_rsp_valid_i = 1'b1;
    bus.ifu_rsp_data_i  = 32'h0070_0393;
    step();
    bus.ifu_rsp_valid_i = 1'b0;
    chk("to_rsp_wins", {halt_o, err_code_o}, 0);
    chk("to_rsp_inst", inst_o, 32'h0070_0393);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
